// File: rtl/dice_roller.sv
// Yacht dice roller: five LFSR-driven dice with hold mask, tick-paced tumble
// animation and a per-turn roll limit.
module dice_roller #(
    parameter int unsigned TICK_DIV   = 2_500_000,
    parameter int unsigned ANIM_STEPS = 10,
    parameter int unsigned MAX_ROLLS  = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       roll_req,
    input  logic       new_turn,
    input  logic [4:0] hold,
    output logic [2:0] d1,
    output logic [2:0] d2,
    output logic [2:0] d3,
    output logic [2:0] d4,
    output logic [2:0] d5,
    output logic       rolling,
    output logic       roll_done,
    output logic       roll_reject,
    output logic [1:0] rolls_used
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = $clog2(ANIM_STEPS + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(ANIM_STEPS - 1);
    localparam logic [1:0]    ROLLS_MAX = 2'(MAX_ROLLS);

    typedef enum logic [1:0] {IDLE, ANIM, DONE} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic          fb;
    logic [PW-1:0] prescale;
    logic [SW-1:0] step;
    logic [2:0]    dice [5];
    logic [2:0]    cand [5];

    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // Out-of-range fields (0 or 7) are folded onto 1..4 using the top LFSR bit.
    always_comb begin
        for (int unsigned k = 0; k < 5; k++) begin
            cand[k] = lfsr[3*k +: 3];
            if (cand[k] == 3'd0 || cand[k] == 3'd7)
                cand[k] = {1'b0, lfsr[15], lfsr[3*k]} + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            prescale    <= '0;
            step        <= '0;
            rolling     <= 1'b0;
            roll_done   <= 1'b0;
            roll_reject <= 1'b0;
            rolls_used  <= '0;
            for (int unsigned k = 0; k < 5; k++) dice[k] <= 3'd1;
        end else begin
            lfsr        <= {lfsr[14:0], fb};
            roll_done   <= 1'b0;
            roll_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_turn) begin
                        rolls_used <= '0;
                    end else if (roll_req) begin
                        if (rolls_used >= ROLLS_MAX || hold == '1) begin
                            roll_reject <= 1'b1;
                        end else begin
                            state    <= ANIM;
                            rolling  <= 1'b1;
                            prescale <= '0;
                            step     <= '0;
                        end
                    end
                end
                ANIM: begin
                    if (new_turn) begin
                        state      <= IDLE;
                        rolling    <= 1'b0;
                        rolls_used <= '0;
                    end else if (prescale == PRE_LAST) begin
                        prescale <= '0;
                        step     <= step + SW'(1);
                        for (int unsigned k = 0; k < 5; k++)
                            if (!hold[k]) dice[k] <= cand[k];
                        if (step == STEP_LAST) begin
                            state     <= DONE;
                            rolling   <= 1'b0;
                            roll_done <= 1'b1;
                        end
                    end else begin
                        prescale <= prescale + PW'(1);
                    end
                end
                DONE: begin
                    if (rolls_used < ROLLS_MAX) rolls_used <= rolls_used + 2'd1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign d1 = dice[0];
    assign d2 = dice[1];
    assign d3 = dice[2];
    assign d4 = dice[3];
    assign d5 = dice[4];

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller: directed rolls with an independent LFSR
// reference; done/reject pulses are checked by a separate monitor.
module tb_dice_roller;

    localparam int unsigned TD = 4;
    localparam int unsigned AS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       roll_req = 1'b0;
    logic       new_turn = 1'b0;
    logic [4:0] hold = 5'b0;
    logic [2:0] d1, d2, d3, d4, d5;
    logic       rolling, roll_done, roll_reject;
    logic [1:0] rolls_used;

    dice_roller #(.TICK_DIV(TD), .ANIM_STEPS(AS), .MAX_ROLLS(3), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .roll_req(roll_req), .new_turn(new_turn), .hold(hold),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5),
        .rolling(rolling), .roll_done(roll_done), .roll_reject(roll_reject),
        .rolls_used(rolls_used)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_done;
        logic [14:0] dice;
        logic [1:0]  used;
    } evt_t;

    evt_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] mdl;
    logic [2:0]  ed [5];
    int          exp_used = 0;

    // Reference LFSR: taps 16,14,13,11 as a parity mask.
    always @(posedge clk or posedge reset)
        if (reset) mdl <= 16'hACE1;
        else       mdl <= {mdl[14:0], ^(mdl & 16'hB400)};

    function automatic logic [2:0] ref_die(input logic [15:0] l, input int k);
        logic [15:0] s;
        logic [2:0]  v;
        s = l >> (3 * k);
        v = s[2:0];
        if (v >= 3'd1 && v <= 3'd6) return v;
        return 3'd1 + 3'(2 * l[15] + s[0]);
    endfunction

    function automatic logic [14:0] pack_ed();
        return {ed[0], ed[1], ed[2], ed[3], ed[4]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int dice_now();
        return int'({d1, d2, d3, d4, d5});
    endfunction

    always @(negedge clk) begin
        if (!reset && (roll_done || roll_reject)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'b0, roll_done, roll_reject}, 0);
            end else begin
                evt_t e;
                e = sb.pop_front();
                chk("pulse_kind", {30'b0, roll_done, roll_reject}, {30'b0, e.is_done, !e.is_done});
                chk("pulse_dice", dice_now(), int'(e.dice));
                chk("pulse_used", int'(rolls_used), int'(e.used));
            end
        end
    end

    // Accepted roll; abort_at>0 pulses new_turn so it is sampled at edge E+abort_at.
    task automatic do_roll(input logic [4:0] h, input int abort_at);
        hold = h;
        roll_req = 1'b1;
        step();
        roll_req = 1'b0;
        chk("rolling_at_E", int'(rolling), 1);
        for (int c = 1; c <= int'(TD * AS); c++) begin
            if (abort_at != 0 && c == abort_at) begin
                new_turn = 1'b1;
                step();
                new_turn = 1'b0;
                exp_used = 0;
                chk("abort_rolling", int'(rolling), 0);
                chk("abort_dice", dice_now(), int'(pack_ed()));
                chk("abort_used", int'(rolls_used), 0);
                return;
            end
            if (c % TD == 0) begin
                for (int k = 0; k < 5; k++)
                    if (!h[k]) ed[k] = ref_die(mdl, k);
                if (c == int'(TD * AS))
                    sb.push_back('{is_done: 1'b1, dice: pack_ed(), used: 2'(exp_used)});
            end
            step();
            if (c < int'(TD * AS)) chk("rolling_mid", int'(rolling), 1);
            else                   chk("rolling_end", int'(rolling), 0);
            if (c % TD == 0) chk("tick_dice", dice_now(), int'(pack_ed()));
        end
        step();
        if (exp_used < 3) exp_used++;
        chk("rolls_used_after", int'(rolls_used), exp_used);
    endtask

    task automatic rejected_roll(input logic [4:0] h);
        hold = h;
        roll_req = 1'b1;
        sb.push_back('{is_done: 1'b0, dice: pack_ed(), used: 2'(exp_used)});
        step();
        roll_req = 1'b0;
        chk("reject_not_rolling", int'(rolling), 0);
        step();
        chk("reject_dice_kept", dice_now(), int'(pack_ed()));
        chk("reject_used", int'(rolls_used), exp_used);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 5; k++) ed[k] = 3'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset_dice", dice_now(), int'(15'b001_001_001_001_001));
            chk("reset_flags", {29'b0, rolling, roll_done, roll_reject}, 0);
            chk("reset_used", int'(rolls_used), 0);
        end
        reset = 1'b0;
        step();

        do_roll(5'b00000, 0);
        do_roll(5'b00101, 0);
        do_roll(5'b00000, 0);
        rejected_roll(5'b00000);

        new_turn = 1'b1;
        step();
        new_turn = 1'b0;
        exp_used = 0;
        chk("new_turn_clears", int'(rolls_used), 0);

        do_roll(5'b00000, 0);
        rejected_roll(5'b11111);
        do_roll(5'b00000, 6);

        new_turn = 1'b1;
        roll_req = 1'b1;
        hold = 5'b00000;
        step();
        new_turn = 1'b0;
        roll_req = 1'b0;
        chk("simul_no_anim", int'(rolling), 0);
        chk("simul_used", int'(rolls_used), 0);
        repeat (20) step();
        chk("idle_after_abort", int'(rolling), 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
